pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC/target width in words (min 28).
REQ-002 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries (power of two, min 2).
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port stall  input  1  hold PC and RAS this cycle.
REQ-007 SHALL have port controle  input  3  next-PC operation code (see Function).
REQ-008 SHALL have port sinal_zero  input  1  ALU zero flag for conditional branches.
REQ-009 SHALL have port branch_target  input  ADDR_W  absolute branch destination.
REQ-010 SHALL have port jump_target  input  28  jump/call field, zero-extended to ADDR_W.
REQ-011 SHALL have port reg_target  input  ADDR_W  register-indirect destination.
REQ-012 SHALL have port pc  output  ADDR_W  registered current PC.
REQ-013 SHALL have port ras_empty, ras_full  output  1 each  stack occupancy flags.
REQ-014 SHALL have port ras_err  output  2  sticky {overflow, underflow} flags.

Function
REQ-015 SHALL compute seq = pc+1 modulo 2^ADDR_W; pc = all-ones wraps to 0.
REQ-016 SHALL select next PC by controle: 000 seq; 001 BEQ (branch_target if sinal_zero=1, else seq); 010 BNE (branch_target if sinal_zero=0, else seq); 011 JUMP (zero-extended jump_target); 100 CALL (jump target, push seq); 101 RET (pop top); 110 JR (reg_target); 111 reserved, behaves as 000.
REQ-017 SHALL register next PC on the rising edge when stall=0; next-PC logic combinational, latency one cycle from controle to pc.
REQ-018 SHALL, when stall=1, hold pc, RAS contents, pointers and flags unchanged, regardless of controle.
REQ-019 SHALL implement RAS as circular buffer with count 0..RAS_DEPTH; ras_empty = (count==0), ras_full = (count==RAS_DEPTH), both combinational from registered state.
REQ-020 SHALL, on CALL with ras_full=1, overwrite the oldest entry, keep count at RAS_DEPTH, set ras_err[1].
REQ-021 SHALL, on RET with ras_empty=1, load seq, leave count at 0, set ras_err[0].
REQ-022 SHALL treat ras_err bits as sticky until reset.
REQ-023 SHALL make the popped value the most recently pushed valid entry (LIFO), including after wrap-around.

Reset
REQ-024 SHALL on reset_n=0 asynchronously set pc=RESET_PC, count=0, pointer=0, ras_err=00; ras_empty=1, ras_full=0.
REQ-025 SHALL abandon any in-flight operation on reset mid-cycle; first update after deassertion uses controle at that edge.
REQ-026 SHALL not require reset of RAS storage entries.

Configuration
REQ-027 SHALL honour macro PC_SEQUENCER_RAS_EN: defined -> RAS built as above.
REQ-028 SHALL, without PC_SEQUENCER_RAS_EN, build no stack: CALL behaves as JUMP, RET behaves as JR, ras_empty=1, ras_full=0, ras_err=00 constant.

Structure
REQ-029 SHALL place opcode constants (3-bit controle encodings) and RESET_PC default in shared package pc_seq_pkg.
REQ-030 SHALL implement the stack as sub-module pc_ras (push, pop, top, empty, full, ovf, unf), instantiated only under PC_SEQUENCER_RAS_EN.

Verification
REQ-031 SHALL cover: reset, controle=000 for 3 cycles -> pc 0,1,2,3; pc=FFFFFFFF, 000 -> pc 0.
REQ-032 SHALL cover: pc=10, BEQ target=40 zero=1 -> 40; BNE target=40 zero=1 -> 11; BNE zero=0 -> 40.
REQ-033 SHALL cover: pc=5, CALL jump_target=100 -> pc 100; RET -> pc 6, ras_empty=1.
REQ-034 SHALL cover: 9 CALLs from pc values 1..9 with RAS_DEPTH=8 -> ras_full=1, ras_err=10; 8 RETs return 10,9..3 order-reversed seq values; 9th RET -> seq, ras_err=11.
REQ-035 SHALL cover: stall=1 with controle=100 for 2 cycles -> pc, count unchanged; reset_n pulse mid-stream -> pc=RESET_PC immediately, flags cleared.
REQ-036 SHALL cover build without PC_SEQUENCER_RAS_EN: CALL target=100 -> 100; RET reg_target=7 -> 7; flags constant.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants for the program-counter sequencer: controle opcodes and reset PC.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pc_seq_pkg;

    // 3-bit controle encodings for next-PC selection
    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_JUMP = 3'b011;
    localparam logic [2:0] OP_CALL = 3'b100;
    localparam logic [2:0] OP_RET  = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Default PC loaded at reset
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Width of the jump/call immediate field
    localparam int JUMP_W = 28;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, overwrites oldest on overflow, sticky ovf/unf.
// Latency: push/pop take effect at the next rising edge; top/empty/full from registered state.
// Backpressure: none; caller gates push/pop (e.g. on stall).
//
// Ports: clock, reset_n (async active-low), push/push_data, pop, top, empty, full,
//        ovf (sticky push-while-full), unf (sticky pop-while-empty).
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         ovf,
    output logic         unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;   // next slot to write
    logic [PTR_W-1:0] rd_ptr;   // most recent valid entry
    logic [CNT_W-1:0] count;

    // Power-of-two depth lets the pointer wrap naturally.
    assign rd_ptr = wr_ptr - PTR_W'(1);
    assign top    = mem[rd_ptr];
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));

    // Storage needs no reset; validity is tracked by count.
    // When full, wr_ptr points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                wr_ptr <= rd_ptr;
                count  <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: seq/branch/jump/call/ret/jr next-PC select with optional RAS.
// Latency: one cycle from controle to pc.
// Backpressure: stall=1 freezes pc and all stack state.
//
// Ports: clock, reset_n (async active-low), stall, controle[2:0], sinal_zero,
//        branch_target, jump_target[27:0], reg_target, pc, ras_empty, ras_full, ras_err[1:0].
// Config macro PC_SEQUENCER_RAS_EN: defined builds the return-address stack; undefined
//        maps CALL to JUMP, RET to JR, and ties the stack flags to empty/no-error.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              stall,
    input  logic [2:0]        controle,
    input  logic              sinal_zero,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [JUMP_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] pc,
    output logic              ras_empty,
    output logic              ras_full,
    output logic [1:0]        ras_err
);

    // Elaboration-time parameter sanity checks
    if (ADDR_W < JUMP_W) begin : g_bad_addr_w
        $error("pc_sequencer: ADDR_W must be at least 28");
    end
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
        $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
    end

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] next_pc;

    assign seq_pc  = pc + ADDR_W'(1);        // wraps all-ones to zero
    assign jump_pc = ADDR_W'(jump_target);   // zero-extend

`ifdef PC_SEQUENCER_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;
`endif

    always_comb begin
        next_pc = seq_pc;
`ifdef PC_SEQUENCER_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
        case (controle)
            OP_BEQ:  if (sinal_zero)  next_pc = branch_target;
            OP_BNE:  if (!sinal_zero) next_pc = branch_target;
            OP_JUMP: next_pc = jump_pc;
            OP_CALL: begin
                next_pc = jump_pc;
`ifdef PC_SEQUENCER_RAS_EN
                ras_push = !stall;
`endif
            end
            OP_RET: begin
`ifdef PC_SEQUENCER_RAS_EN
                // Pop from an empty stack falls through to the sequential PC.
                ras_pop = !stall;
                next_pc = ras_empty ? seq_pc : ras_top;
`else
                next_pc = reg_target;
`endif
            end
            OP_JR:   next_pc = reg_target;
            default: next_pc = seq_pc;       // OP_SEQ and reserved OP_RSVD
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

`ifdef PC_SEQUENCER_RAS_EN
    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ovf       (ras_err[1]),
        .unf       (ras_err[0])
    );
`else
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_err   = 2'b00;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer (default build and PC_SEQUENCER_RAS_EN build).
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        stall;
    logic [2:0]  controle;
    logic        sinal_zero;
    logic [31:0] branch_target;
    logic [27:0] jump_target;
    logic [31:0] reg_target;
    logic [31:0] pc;
    logic        ras_empty;
    logic        ras_full;
    logic [1:0]  ras_err;

    pc_sequencer #(
        .ADDR_W    (32),
        .RAS_DEPTH (8),
        .RESET_PC  (32'h0)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .stall         (stall),
        .controle      (controle),
        .sinal_zero    (sinal_zero),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .pc            (pc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_err       (ras_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        st;
        logic [2:0]  ctl;
        logic        z;
        logic [31:0] bt;
        logic [27:0] jt;
        logic [31:0] rt;
        logic [31:0] epc;
        logic        ee;
        logic        ef;
        logic [1:0]  eerr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic [2:0] ctl, input logic z,
                                input logic [31:0] bt, input logic [27:0] jt,
                                input logic [31:0] rt, input logic [31:0] epc,
                                input logic ee, input logic ef, input logic [1:0] eerr);
        vec_t v;
        v.st = st; v.ctl = ctl; v.z = z; v.bt = bt; v.jt = jt; v.rt = rt;
        v.epc = epc; v.ee = ee; v.ef = ef; v.eerr = eerr;
        return v;
    endfunction

    // Caller is at a falling edge; drives, waits one rising edge, samples 1 unit later,
    // then returns at the following falling edge.
    task automatic apply(input vec_t v, input int idx);
        stall         = v.st;
        controle      = v.ctl;
        sinal_zero    = v.z;
        branch_target = v.bt;
        jump_target   = v.jt;
        reg_target    = v.rt;
        @(posedge clock);
        #1;
        check($sformatf("vec%0d_pc", idx),    pc,        v.epc);
        check($sformatf("vec%0d_empty", idx), {31'b0, ras_empty}, {31'b0, v.ee});
        check($sformatf("vec%0d_full", idx),  {31'b0, ras_full},  {31'b0, v.ef});
        check($sformatf("vec%0d_err", idx),   {30'b0, ras_err},   {30'b0, v.eerr});
        @(negedge clock);
    endtask

    initial begin
        reset_n       = 1'b0;
        stall         = 1'b0;
        controle      = OP_SEQ;
        sinal_zero    = 1'b0;
        branch_target = '0;
        jump_target   = '0;
        reg_target    = '0;

        // Common rows: identical expectations in both builds (stack never touched)
        vecs.push_back(mk(0, OP_SEQ,  0, 0,  0,  0,            32'd1,        1, 0, 2'b00));
        vecs.push_back(mk(0, OP_SEQ,  0, 0,  0,  0,            32'd2,        1, 0, 2'b00));
        vecs.push_back(mk(0, OP_SEQ,  0, 0,  0,  0,            32'd3,        1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JR,   0, 0,  0,  32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 2'b00));
        vecs.push_back(mk(0, OP_SEQ,  0, 0,  0,  0,            32'd0,        1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JR,   0, 0,  0,  32'd10,       32'd10,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_BEQ,  1, 40, 0,  0,            32'd40,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JR,   0, 0,  0,  32'd10,       32'd10,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_BNE,  1, 40, 0,  0,            32'd11,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JR,   0, 0,  0,  32'd10,       32'd10,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_BNE,  0, 40, 0,  0,            32'd40,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_BEQ,  0, 99, 0,  0,            32'd41,       1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JUMP, 0, 0,  28'hFFFFFFF, 0,   32'h0FFFFFFF, 1, 0, 2'b00));
        vecs.push_back(mk(0, OP_RSVD, 0, 0,  0,  0,            32'h10000000, 1, 0, 2'b00));
        vecs.push_back(mk(1, OP_CALL, 0, 0,  100, 0,           32'h10000000, 1, 0, 2'b00));
        vecs.push_back(mk(1, OP_CALL, 0, 0,  100, 0,           32'h10000000, 1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JR,   0, 0,  0,  32'd5,        32'd5,        1, 0, 2'b00));
`ifdef PC_SEQUENCER_RAS_EN
        vecs.push_back(mk(0, OP_CALL, 0, 0,  100, 0,           32'd100,      0, 0, 2'b00));
        vecs.push_back(mk(0, OP_RET,  0, 0,  0,  32'd7,        32'd6,        1, 0, 2'b00));
        vecs.push_back(mk(0, OP_JR,   0, 0,  0,  32'd1,        32'd1,        1, 0, 2'b00));
        // CALL from pc=k with target k+1 pushes k+1; the ninth overwrites the oldest (2)
        for (int k = 1; k <= 9; k++) begin
            vecs.push_back(mk(0, OP_CALL, 0, 0, 28'(k + 1), 0, 32'(k + 1),
                              0, (k >= 8), (k == 9) ? 2'b10 : 2'b00));
        end
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(0, OP_RET, 0, 0, 0, 32'd7, 32'(10 - i),
                              (i == 7), 0, 2'b10));
        end
        vecs.push_back(mk(0, OP_RET,  0, 0,  0,  32'd7,        32'd4,        1, 0, 2'b11));
`else
        vecs.push_back(mk(0, OP_CALL, 0, 0,  100, 0,           32'd100,      1, 0, 2'b00));
        vecs.push_back(mk(0, OP_RET,  0, 0,  0,  32'd7,        32'd7,        1, 0, 2'b00));
        vecs.push_back(mk(0, OP_RET,  0, 0,  0,  32'd9,        32'd9,        1, 0, 2'b00));
`endif

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_pc",    pc,                  32'h0);
        check("reset_empty", {31'b0, ras_empty},  32'd1);
        check("reset_full",  {31'b0, ras_full},   32'd0);
        check("reset_err",   {30'b0, ras_err},    32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], i);
        end

        // Reset pulse mid-cycle: pc and flags clear immediately, no clock edge needed
        stall    = 1'b0;
        controle = OP_SEQ;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_pc",    pc,                 32'h0);
        check("midrst_empty", {31'b0, ras_empty}, 32'd1);
        check("midrst_full",  {31'b0, ras_full},  32'd0);
        check("midrst_err",   {30'b0, ras_err},   32'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        controle = OP_JUMP;
        jump_target = 28'd77;
        @(posedge clock);
        #1;
        check("postrst_pc", pc, 32'd77);
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
